// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: 16-entry write FIFO, baud counter and framing FSM on one clock.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1) before the stop bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_AW      = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic             sclk,
  input  logic             reset,
  input  logic             wr,
  input  logic [7:0]       data,
  input  logic             clr_ovf,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] level,
  output logic             busy,
  output logic             overflow
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2 || PARITY_ODD > 1'b1) begin : g_bad_cfg
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                dout_q, dout_d;
  logic                ovf_q, ovf_d;
  logic [FIFO_AW:0]    wptr_q, rptr_q;
  logic [7:0]          mem_q [DEPTH];
  logic [7:0]          head;
  logic                push, pop, tick;
`ifdef UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                    (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign level    = wptr_q - rptr_q;
  assign busy     = (state_q != IDLE) || !empty;
  assign overflow = ovf_q;
  assign dout     = dout_q;
  assign head     = mem_q[rptr_q[FIFO_AW-1:0]];
  assign push     = wr && !full;

  // A dropped write takes priority over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wr && full) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    dout_d  = 1'b1;
    tick    = (baud_q == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) begin
      baud_d = tick ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        // Back-to-back frames: pop straight into START with no idle gap.
        if (tick) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shreg_d = head;
`ifdef UART_TX_PARITY_EN
      par_d   = (^head) ^ PARITY_ODD;
`endif
    end
    // Line level is registered from the state being entered.
    case (state_d)
      START:   dout_d = 1'b0;
      DATA:    dout_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  dout_d = par_q;
`endif
      default: dout_d = 1'b1;
    endcase
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      dout_q  <= 1'b1;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge sclk) begin
    if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= data;
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized scoreboard bench for uart_tx_fifo: a frame-level model predicts every line bit and flag.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam bit PODD  = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          sclk = 1'b0;
  logic          reset = 1'b0;
  logic          wr = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          dout, full, empty, busy, overflow;
  logic [AW:0]   level;

  int            checks = 0;
  int            failures = 0;

  logic [7:0]    exp_q[$];
  int            m_cnt = 0;
  int            m_pos = -1;
  bit            m_ovf = 1'b0;
  logic [7:0]    m_cur = 8'h00;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW), .PARITY_ODD(PODD)) dut (
    .sclk(sclk), .reset(reset), .wr(wr), .data(data), .clr_ovf(clr_ovf),
    .dout(dout), .full(full), .empty(empty), .level(level), .busy(busy),
    .overflow(overflow)
  );

  always #5 sclk = ~sclk;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return (^b) ^ PODD;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: advance the frame-level model one clock and compare every output.
  always begin
    @(posedge sclk);
    #1;
    if (!reset) begin
      m_cnt = 0;
      m_pos = -1;
      m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      bit full_pre;
      bit acc;
      full_pre = (m_cnt == DEPTH);
      acc = wr && !full_pre;
      if (wr && full_pre) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (m_pos >= 0) m_pos = (m_pos == FRAME - 1) ? -1 : m_pos + 1;
      if (m_pos < 0 && m_cnt > 0) begin
        m_pos = 0;
        m_cnt--;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty actual=0 required=1 at %0t", $time);
        end else begin
          m_cur = exp_q.pop_front();
        end
      end
      if (acc) m_cnt++;
      chk("dout", dout, (m_pos < 0) ? 1'b1 : frame_bit(m_cur, m_pos / CPB));
      chk("level", level, m_cnt);
      chk("full", full, m_cnt == DEPTH);
      chk("empty", empty, m_cnt == 0);
      chk("busy", busy, (m_pos >= 0) || (m_cnt > 0));
      chk("overflow", overflow, m_ovf);
    end
  end

  // Drive one clock's inputs at a falling edge, then wait for the next falling edge.
  task automatic cycle(input bit w, input logic [7:0] b, input bit c);
    wr = w;
    data = b;
    clr_ovf = c;
    if (w && m_cnt < DEPTH) exp_q.push_back(b);
    @(negedge sclk);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 * FRAME; i++) begin
      if (m_pos < 0 && m_cnt == 0) begin
        done = 1'b1;
        break;
      end
      cycle(1'b0, 8'h00, 1'b0);
    end
    chk("drain_done", done, 1'b1);
    chk("drain_busy", busy, 1'b0);
  endtask

  initial begin
    bit hit;
    int pct;
    @(negedge sclk);
    @(negedge sclk);
    chk("rst_dout", dout, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    @(negedge sclk);
    reset = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);

    // Single byte: stored at edge k, popped at k+1.
    cycle(1'b1, 8'hA5, 1'b0);
    chk("a5_level_k", level, 1);
    chk("a5_dout_k", dout, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("a5_level_k1", level, 0);
    chk("a5_dout_k1", dout, 1'b0);
    wait_idle();

    // 17 back-to-back writes, then an 18th into a full FIFO.
    for (int i = 0; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0);
    chk("fill_full", full, 1'b1);
    chk("fill_level", level, 16);
    chk("fill_ovf", overflow, 1'b0);
    cycle(1'b1, 8'h11, 1'b0);
    chk("drop_ovf", overflow, 1'b1);
    chk("drop_level", level, 16);
    cycle(1'b0, 8'h00, 1'b1);
    chk("clr_ovf", overflow, 1'b0);

    // Write into a full FIFO on the very edge the head is popped.
    hit = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (m_pos == FRAME - 1 && m_cnt == DEPTH) begin
        hit = 1'b1;
        break;
      end
      cycle(1'b0, 8'h00, 1'b0);
    end
    chk("pop_edge_found", hit, 1'b1);
    cycle(1'b1, 8'h55, 1'b0);
    chk("pop_drop_level", level, 15);
    chk("pop_drop_ovf", overflow, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    wait_idle();

    // Three queued bytes stream as contiguous frames.
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    wait_idle();

    // Reset mid-DATA of a 0xFF frame with more bytes queued.
    cycle(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 3 * CPB; i++) cycle(1'b0, 8'h00, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 1'b1);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge sclk);
    @(negedge sclk);
    @(negedge sclk);
    reset = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) cycle(1'b0, 8'h00, 1'b0);

    // Randomized traffic with varying write density; pointers wrap many times.
    for (int seg = 0; seg < 6; seg++) begin
      pct = (seg % 3 == 0) ? 8 : (seg % 3 == 1) ? 40 : 95;
      for (int i = 0; i < 400; i++) begin
        cycle($urandom_range(0, 99) < pct, 8'($urandom), $urandom_range(0, 15) == 0);
      end
    end
    cycle(1'b0, 8'h00, 1'b1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
